mult_sa_rk: RTL
===============

Name: mult_sa_rk

Overview:
Radix-2^R shift-accumulate multiplier, successor to the blocking shift-accumulate multiplier in the math library. It retires R multiplier bits per cycle and captures its operands on a valid/ready handshake, so inputs need not stay stable during calculation. It holds the result under output back-pressure and accepts a new operation in the same cycle the previous result is consumed. Used wherever an area-lean multiplier with configurable latency is needed.

Parameters:
A_DW, 8, multiplicand-side operand width (>=2)
B_DW, 8, multiplier-side operand width (>=2)
R, 2, multiplier bits retired per iteration (1..MIN(A_DW,B_DW))
C_DW, A_DW+B_DW, product width (derived, do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
tc_mode_i  in  2  two's complement select; bit0 applies to a_i, bit1 to b_i; 1=signed
in_vld_i  in  1  operand valid
in_rdy_o  out  1  operand ready
a_i  in  A_DW  operand A
b_i  in  B_DW  operand B
c_vld_o  out  1  product valid
c_rdy_i  in  1  product ready
c_o  out  C_DW  product
busy_o  out  1  calculation in progress

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state=IDLE, c_vld_o=0, c_o=0, busy_o=0, in_rdy_o=1.
- Operand roles: M = wider operand (multiplicand); N = narrower operand (multiplier); tie -> M=a. ITER = ceil(N_DW/R). The multiplier is zero-padded to ITER*R bits.
- Operand capture: on in_vld_i&in_rdy_o, register the magnitudes |a|, |b| per tc_mode_i. Also register c_neg = a_neg^b_neg. Later changes on any input are ignored.
- FSM states IDLE, CALC, DONE:
  - IDLE: in_rdy_o=1; on handshake go to CALC, iteration counter=0.
  - CALC: busy_o=1; each cycle H += M*n[R-1:0], where n[R-1:0] is the low R bits of the low register, computed as an (M_DW+R)-bit partial product. The {H,L} register then shifts right logically by R. Counter increments; at ITER-1 go to DONE.
  - DONE: c_o = c_neg ? -P : P, using the low C_DW bits of the product, registered on entry. c_vld_o=1.
    - On c_rdy_i: if in_vld_i is also high, accept new operands in the same cycle (in_rdy_o = c_rdy_i in DONE) and go to CALC. Otherwise go to IDLE.
- Latency: handshake in cycle t -> c_vld_o high in cycle t+ITER+1. Throughput is one result per ITER+1 cycles with c_rdy_i tied high.
- Back-pressure: while c_vld_o=1 and c_rdy_i=0, c_o is held stable and in_rdy_o=0.
- Arithmetic: internal math is unsigned on magnitudes. Most-negative operands are exact: -2^(A_DW-1) magnitude fits in A_DW unsigned bits. No overflow is possible in C_DW.
- Input edge cases: in_vld_i while busy is ignored, not an error. tc_mode_i is sampled only at handshake.
- Reset mid-operation: returns to the reset values immediately. A partial result is never emitted.

Optional Feature:
MULT_SA_RK_EARLY_TERM_EN
- Defined: CALC exits to DONE as soon as the unconsumed multiplier bits are all zero. The remaining shift amount is applied in one step by a barrel alignment, so latency varies between 2 and ITER+1 cycles. Result values are unchanged.
- Undefined: fixed latency ITER+1. No barrel shifter is built.

Decomposition:
- math_pkg: mult_state_e enum (IDLE/CALC/DONE), function iter_cnt(n_dw, r) returning ceil division, function abs_tc(value, tc) for conditional negation.
- Sub-module mult_sa_rk_pp: combinational M_DW x R partial-product generator. It is isolated so R=1 reduces to an AND-gate array.

Test Plan:
- Unsigned, R=2, 8x8: a=255, b=255, tc=00 -> c_o=0xFE01 at handshake+5, c_vld_o for 1 cycle with c_rdy_i=1.
- Signed extremes: a=0x80, b=0x80, tc=11 -> 0x4000. a=0xFD, b=0x05 -> 0xFFF1.
- Mixed sign: tc=01, a=0xFF (-1), b=0xFF (255) -> 0xFF01. tc=10, same operands -> 0xFF01.
- Back-pressure and back-to-back: hold c_rdy_i=0 for 3 cycles -> c_o stable, in_rdy_o=0. Then raise c_rdy_i with in_vld_i=1 (3*4) -> accepted in that cycle, next result 12 after 5 more cycles.
- Odd width: A_DW=12, B_DW=5, R=2, a=0xFFF, b=0x1F unsigned -> ITER=3, c_o=0x1EFE1 at handshake+4.
- Reset mid-CALC: drop rst_ni in iteration 2 -> c_vld_o=0, busy_o=0, in_rdy_o=1 immediately. With MULT_SA_RK_EARLY_TERM_EN, b=1 -> c_vld_o at handshake+2.

Source files
------------

// File: rtl/math_pkg.sv
// Shared types and helpers for the shift-accumulate multiplier family:
// FSM state encoding, iteration-count arithmetic and two's complement magnitude.
package math_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    function automatic int iter_cnt(input int n_dw, input int r);
        return (n_dw + r - 1) / r;
    endfunction

    // Magnitude of a value already sign-extended to 64 bits; unsigned when tc=0.
    function automatic logic [63:0] abs_tc(input logic [63:0] value, input logic tc);
        return (tc && value[63]) ? (~value + 64'd1) : value;
    endfunction

endpackage

// File: rtl/mult_sa_rk_pp.sv
// M_DW x R partial-product generator: sum of the multiplicand shifted by each
// set bit of the R-bit multiplier digit. For R=1 this collapses to an AND array.
module mult_sa_rk_pp #(
    parameter int M_DW = 8,
    parameter int R    = 2
) (
    input  logic [M_DW-1:0]   m,
    input  logic [R-1:0]      n,
    output logic [M_DW+R-1:0] pp
);

    always_comb begin
        // NOTE: combinational outputs get a default before any conditional update so no latch is inferred.
        pp = '0;
        for (int i = 0; i < R; i++) begin
            if (n[i]) pp = pp + ((M_DW + R)'(m) << i);
        end
    end

endmodule

// File: rtl/mult_sa_rk.sv
// Radix-2^R shift-accumulate multiplier with valid/ready operand and product handshakes.
// Optional MULT_SA_RK_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are zero.
module mult_sa_rk
    import math_pkg::*;
#(
    parameter int A_DW = 8,
    parameter int B_DW = 8,
    parameter int R    = 2,
    localparam int C_DW = A_DW + B_DW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [1:0]      tc_mode_i,
    input  logic            in_vld_i,
    output logic            in_rdy_o,
    input  logic [A_DW-1:0] a_i,
    input  logic [B_DW-1:0] b_i,
    output logic            c_vld_o,
    input  logic            c_rdy_i,
    output logic [C_DW-1:0] c_o,
    output logic            busy_o
);

    localparam int M_DW = (A_DW >= B_DW) ? A_DW : B_DW;
    localparam int N_DW = (A_DW >= B_DW) ? B_DW : A_DW;
    localparam int ITER = iter_cnt(N_DW, R);
    localparam int NP   = ITER * R;
    localparam int CW   = $clog2(ITER + 1);

    mult_state_e       state_q;
    logic [CW-1:0]     cnt_q;
    logic [M_DW-1:0]   m_q;
    logic [M_DW-1:0]   h_q;
    logic [NP-1:0]     l_q;
    logic              c_neg_q;
    logic [C_DW-1:0]   c_q;
    logic              c_vld_q;
    logic              busy_q;

    logic              a_neg, b_neg, accept, last, done_now;
    logic [A_DW-1:0]   a_mag;
    logic [B_DW-1:0]   b_mag;
    logic [M_DW-1:0]   m_in;
    logic [N_DW-1:0]   n_in;
    logic [M_DW+R-1:0] pp, sum;
    logic [M_DW+NP-1:0] step, prod;
    logic [C_DW-1:0]   p, result;

    assign a_neg = tc_mode_i[0] & a_i[A_DW-1];
    assign b_neg = tc_mode_i[1] & b_i[B_DW-1];
    assign a_mag = A_DW'(abs_tc({{(64 - A_DW){a_neg}}, a_i}, tc_mode_i[0]));
    assign b_mag = B_DW'(abs_tc({{(64 - B_DW){b_neg}}, b_i}, tc_mode_i[1]));

    // The wider operand is the multiplicand so the iteration count follows the narrower one.
    if (A_DW >= B_DW) begin : g_a_is_m
        assign m_in = a_mag;
        assign n_in = b_mag;
    end else begin : g_b_is_m
        assign m_in = b_mag;
        assign n_in = a_mag;
    end

    assign in_rdy_o = (state_q == IDLE) || ((state_q == DONE) && c_rdy_i);
    assign accept   = in_vld_i && in_rdy_o;

    mult_sa_rk_pp #(.M_DW(M_DW), .R(R)) u_pp (
        .m  (m_q),
        .n  (l_q[R-1:0]),
        .pp (pp)
    );

    assign sum  = {{R{1'b0}}, h_q} + pp;
    assign step = (M_DW + NP)'({sum, l_q} >> R);
    assign last = (cnt_q == CW'(ITER - 1));

`ifdef MULT_SA_RK_EARLY_TERM_EN
    int            shamt;
    logic [NP-1:0] rest;

    // After this step the low shamt bits of the shifted L are still unconsumed multiplier bits.
    always_comb begin
        shamt = (ITER - 1 - int'(cnt_q)) * R;
        rest  = (l_q >> R) & ~({NP{1'b1}} << shamt);
    end

    assign done_now = last || (rest == '0);
    assign prod     = step >> shamt;
`else
    assign done_now = last;
    assign prod     = step;
`endif

    assign p      = C_DW'(prod);
    assign result = c_neg_q ? -p : p;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            h_q     <= '0;
            l_q     <= '0;
            c_neg_q <= 1'b0;
            c_q     <= '0;
            c_vld_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every read sees the pre-edge value.
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                    end
                end
                CALC: begin
                    h_q <= step[M_DW+NP-1:NP];
                    l_q <= step[NP-1:0];
                    if (done_now) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        c_vld_q <= 1'b1;
                        c_q     <= result;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (c_rdy_i) begin
                        c_vld_q <= 1'b0;
                        state_q <= in_vld_i ? CALC : IDLE;
                        busy_q  <= in_vld_i;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Capture happens only in IDLE or a consumed DONE, never while CALC updates H/L.
            if (accept) begin
                m_q     <= m_in;
                h_q     <= '0;
                l_q     <= NP'(n_in);
                cnt_q   <= '0;
                c_neg_q <= a_neg ^ b_neg;
            end
        end
    end

    assign c_o     = c_q;
    assign c_vld_o = c_vld_q;
    assign busy_o  = busy_q;

endmodule
